// File: rtl/booth_mult_sequencer_if.sv
// Handshake and Booth-core bundle for booth_mult_sequencer.
// "master" is the environment (producer, consumer and Booth core); "slave" is the sequencer.
interface booth_mult_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_m;
  logic [WIDTH-1:0]     in_q;
  logic                 mul_start;
  logic [WIDTH-1:0]     mul_data;
  logic                 mul_rst;
  logic                 mul_done;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_q;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_prod;
  logic                 out_err;
  logic                 busy;
  logic [CNT_W-1:0]     op_count;

  modport master (
    output in_valid, in_m, in_q, mul_done, mul_a, mul_q, out_ready,
    input  in_ready, mul_start, mul_data, mul_rst, out_valid, out_prod, out_err, busy, op_count
  );

  modport slave (
    input  in_valid, in_m, in_q, mul_done, mul_a, mul_q, out_ready,
    output in_ready, mul_start, mul_data, mul_rst, out_valid, out_prod, out_err, busy, op_count
  );
endinterface

// File: rtl/booth_mult_sequencer.sv
// Sequences operand loading into a Booth multiplier core, waits for done (with timeout),
// and returns the captured product over a valid/ready output.
module booth_mult_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic                    clk,
  input logic                    rst,
  booth_mult_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LDM   = 3'd2,
    S_LDQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_RSTM  = 3'd5,
    S_OUT   = 3'd6
  } state_e;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     op_m_q, op_m_d;
  logic [WIDTH-1:0]     op_q_q, op_q_d;
  logic [WIDTH-1:0]     mul_data_q, mul_data_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_m_q     <= {WIDTH{1'b0}};
      op_q_q     <= {WIDTH{1'b0}};
      mul_data_q <= {WIDTH{1'b0}};
      cnt_q      <= {TW{1'b0}};
      prod_q     <= {(2*WIDTH){1'b0}};
      err_q      <= 1'b0;
      count_q    <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      op_m_q     <= op_m_d;
      op_q_q     <= op_q_d;
      mul_data_q <= mul_data_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_m_d  = op_m_q;
    op_q_d  = op_q_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_m_d  = bus.in_m;
          op_q_d  = bus.in_q;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: state_d = S_LDM;
      S_LDM:   state_d = S_LDQ;
      S_LDQ: begin
        cnt_d   = {TW{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a coincident timeout
        if (bus.mul_done) begin
          prod_d  = {bus.mul_a, bus.mul_q};
          err_d   = 1'b0;
          state_d = S_RSTM;
        end else if (cnt_q == TO_LAST) begin
          prod_d  = {(2*WIDTH){1'b0}};
          err_d   = 1'b1;
          state_d = S_RSTM;
        end else begin
          cnt_d   = cnt_q + TW'(1);
          state_d = S_WAIT;
        end
      end
      S_RSTM: state_d = S_OUT;
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          if (!err_q && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
          end else begin
            count_d = count_q;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Operand bus is registered, so it is selected from the upcoming state
    case (state_d)
      S_LDM:   mul_data_d = op_m_q;
      S_LDQ:   mul_data_d = op_q_q;
      default: mul_data_d = {WIDTH{1'b0}};
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mul_start = (state_q == S_START);
  assign bus.mul_rst   = (state_q == S_RSTM);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.mul_data  = mul_data_q;
  assign bus.out_prod  = prod_q;
  assign bus.out_err   = err_q;
  assign bus.op_count  = count_q;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Bench for booth_mult_sequencer: behavioural Booth core, vector table, corner sequences, random ops.
module tb_booth_mult_sequencer;

  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_sequencer_if #(.WIDTH(8), .CNT_W(16)) b0 ();
  booth_mult_sequencer_if #(.WIDTH(8), .CNT_W(2))  b1 ();

  booth_mult_sequencer #(.WIDTH(8), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  booth_mult_sequencer #(.WIDTH(8), .TIMEOUT(TIMEOUT), .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Second instance only differs in counter width, so it shadows the first one's inputs.
  assign b1.in_valid  = b0.in_valid;
  assign b1.in_m      = b0.in_m;
  assign b1.in_q      = b0.in_q;
  assign b1.mul_done  = b0.mul_done;
  assign b1.mul_a     = b0.mul_a;
  assign b1.mul_q     = b0.mul_q;
  assign b1.out_ready = b0.out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int start_cnt = 0;
  int rst_cnt   = 0;

  int cm_phase = 0;
  int cm_cnt   = 0;
  int cm_lat   = 0;
  bit cm_never = 1'b0;
  bit cm_early = 1'b0;
  logic [7:0] cm_m, cm_q;

  function automatic logic [15:0] ref_prod(input logic [7:0] m, input logic [7:0] q);
    int p;
    p = $signed(m) * $signed(q);
    return p[15:0];
  endfunction

  // Behavioural Booth core: takes M then Q off the bus after start, answers after cm_lat cycles.
  always @(posedge clk) begin
    if (rst || b0.mul_rst) begin
      cm_phase    <= 0;
      b0.mul_done <= 1'b0;
    end else begin
      case (cm_phase)
        0: if (b0.mul_start) begin
          cm_phase <= 1;
          if (cm_early) begin
            b0.mul_done <= 1'b1;
            b0.mul_a    <= 8'hDE;
            b0.mul_q    <= 8'hAD;
          end
        end
        1: begin
          cm_m     <= b0.mul_data;
          cm_phase <= 2;
        end
        2: begin
          cm_q        <= b0.mul_data;
          cm_cnt      <= 0;
          b0.mul_done <= 1'b0;
          cm_phase    <= 3;
        end
        3: if (!cm_never) begin
          if (cm_cnt >= cm_lat) begin
            {b0.mul_a, b0.mul_q} <= ref_prod(cm_m, cm_q);
            b0.mul_done <= 1'b1;
            cm_phase    <= 4;
          end else begin
            cm_cnt <= cm_cnt + 1;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (b0.mul_start) start_cnt <= start_cnt + 1;
    if (b0.mul_rst)   rst_cnt   <= rst_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_counts();
    chk("op_count", {16'd0, b0.op_count}, exp_cnt);
    chk("op_count_sat", {30'd0, b1.op_count}, (exp_cnt > 3) ? 3 : exp_cnt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, {31'd0, b0.in_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, b0.busy}, 32'd0);
    chk({tag, "_mul_start"}, {31'd0, b0.mul_start}, 32'd0);
    chk({tag, "_mul_rst"}, {31'd0, b0.mul_rst}, 32'd0);
    chk({tag, "_mul_data"}, {24'd0, b0.mul_data}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, b0.out_valid}, 32'd0);
    chk({tag, "_out_prod"}, {16'd0, b0.out_prod}, 32'd0);
    chk({tag, "_out_err"}, {31'd0, b0.out_err}, 32'd0);
    chk({tag, "_op_count"}, {16'd0, b0.op_count}, 32'd0);
    chk({tag, "_op_count_sat"}, {30'd0, b1.op_count}, 32'd0);
  endtask

  // One full transaction: handshake in, busy-time noise on in_valid, result check, optional back-pressure.
  task automatic do_op(input logic [7:0] m, input logic [7:0] q, input int lat, input int hold,
                       input logic [15:0] exp_prod, input logic exp_err);
    int n;
    int s0;
    int r0;
    logic [15:0] held;
    cm_lat = lat;
    b0.out_ready = (hold == 0);
    n = 0;
    while (!b0.in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", {31'd0, b0.in_ready}, 32'd1);
    s0 = start_cnt;
    r0 = rst_cnt;
    b0.in_m = m;
    b0.in_q = q;
    b0.in_valid = 1'b1;
    @(posedge clk); #1;
    b0.in_m = ~m;
    b0.in_q = ~q;
    n = 0;
    while (!b0.out_valid && n < 300) begin
      if (n >= 3) b0.in_valid = 1'b0;
      @(posedge clk); #1; n++;
    end
    b0.in_valid = 1'b0;
    chk("latency", n, exp_err ? (TIMEOUT + 4) : (lat + 6));
    chk("out_prod", {16'd0, b0.out_prod}, {16'd0, exp_prod});
    chk("out_err", {31'd0, b0.out_err}, {31'd0, exp_err});
    chk("mul_start_pulses", start_cnt - s0, 32'd1);
    chk("mul_rst_pulses", rst_cnt - r0, 32'd1);
    chk("core_saw_m", {24'd0, cm_m}, {24'd0, m});
    chk("core_saw_q", {24'd0, cm_q}, {24'd0, q});
    held = b0.out_prod;
    for (int i = 0; i < hold; i++) begin
      b0.in_valid = 1'b1;
      b0.in_m = 8'h11;
      b0.in_q = 8'h22;
      @(posedge clk); #1;
      chk("hold_out_valid", {31'd0, b0.out_valid}, 32'd1);
      chk("hold_out_prod", {16'd0, b0.out_prod}, {16'd0, held});
      chk("hold_in_ready", {31'd0, b0.in_ready}, 32'd0);
    end
    b0.in_valid = 1'b0;
    b0.out_ready = 1'b1;
    @(posedge clk); #1;
    if (!exp_err) exp_cnt++;
    chk("post_accept_out_valid", {31'd0, b0.out_valid}, 32'd0);
    chk("post_accept_in_ready", {31'd0, b0.in_ready}, 32'd1);
    chk_counts();
  endtask

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    int          lat;
    int          hold;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 0,  0,  16'h000F};
    vecs[1] = '{8'h05, 8'hFD, 5,  0,  16'hFFF1};
    vecs[2] = '{8'h80, 8'h80, 17, 0,  16'h4000};
    vecs[3] = '{8'hFF, 8'hFF, 3,  10, 16'h0001};
    vecs[4] = '{8'h7F, 8'h80, 18, 0,  16'hC080};
    vecs[5] = '{8'h00, 8'h5A, 1,  2,  16'h0000};
    vecs[6] = '{8'h7F, 8'h7F, 9,  0,  16'h3F01};

    b0.in_valid  = 1'b0;
    b0.in_m      = 8'h00;
    b0.in_q      = 8'h00;
    b0.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].m, vecs[i].q, vecs[i].lat, vecs[i].hold, vecs[i].prod, 1'b0);
    end

    cm_never = 1'b1;
    do_op(8'h12, 8'h34, 0, 0, 16'h0000, 1'b1);
    cm_never = 1'b0;

    cm_early = 1'b1;
    do_op(8'h06, 8'hF9, 4, 0, 16'hFFD6, 1'b0);
    cm_early = 1'b0;

    // Reset while the sequencer is parked in WAIT
    cm_never = 1'b1;
    b0.in_m = 8'h21;
    b0.in_q = 8'h43;
    b0.in_valid = 1'b1;
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("busy_before_rst", {31'd0, b0.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("midop_rst");
    cm_never = 1'b0;
    exp_cnt = 0;
    do_op(8'h07, 8'h07, 2, 0, 16'h0031, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] rm;
      logic [7:0] rq;
      rm = 8'($urandom_range(0, 255));
      rq = 8'($urandom_range(0, 255));
      do_op(rm, rq, $urandom_range(0, 18), $urandom_range(0, 3), ref_prod(rm, rq), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
